// File: rtl/fifo_word_packer_if.sv
// Purpose: handshake bundle between the word packer, its upstream show-ahead
//          FIFO and the downstream packed-word consumer.
// Signals:
//   fifo_empty     - upstream FIFO empty flag
//   fifo_read_data - upstream FIFO head word (valid while fifo_empty = 0)
//   fifo_pop       - pop strobe to the upstream FIFO
//   flush          - single-cycle request to emit a partially filled word
//   out_valid      - packed word available
//   out_ready      - downstream accepts the packed word
//   out_data       - packed word, lane 0 holds the first word
//   out_count      - number of valid lanes in out_data
// Modports: master = packer side, slave = environment side.
interface fifo_word_packer_if #(
    parameter int width = 8,
    parameter int ratio = 4
);
    localparam int count_width = $clog2(ratio + 1);

    logic                     fifo_empty;
    logic [width-1:0]         fifo_read_data;
    logic                     fifo_pop;
    logic                     flush;
    logic                     out_valid;
    logic                     out_ready;
    logic [width*ratio-1:0]   out_data;
    logic [count_width-1:0]   out_count;

    modport master (
        input  fifo_empty, fifo_read_data, flush, out_ready,
        output fifo_pop, out_valid, out_data, out_count
    );

    modport slave (
        output fifo_empty, fifo_read_data, flush, out_ready,
        input  fifo_pop, out_valid, out_data, out_count
    );
endinterface

// File: rtl/fifo_word_packer.sv
// Purpose: packs `ratio` consecutive words of width `width` from a show-ahead
//          FIFO into one wide word; a flush emits a partially filled word with
//          the unused lanes zeroed.
// Ports:
//   clk - clock, rising edge
//   rst - asynchronous active-high reset
//   bus - fifo_word_packer_if.master (FIFO pop side + packed output side)
module fifo_word_packer #(
    parameter int width = 8,
    parameter int ratio = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_word_packer_if.master   bus
);
    localparam int cw = $clog2(ratio + 1);
    localparam int dw = width * ratio;
    localparam logic [cw-1:0] full_count = cw'(ratio);
    localparam logic [cw-1:0] zero_count = {cw{1'b0}};
    localparam logic [cw-1:0] one_count  = {{(cw-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [dw-1:0]   acc_data_r;
    logic [dw-1:0]   acc_data_nxt_s;
    logic [cw-1:0]   acc_count_r;
    logic [cw-1:0]   acc_count_nxt_s;
    logic [dw-1:0]   out_data_r;
    logic [cw-1:0]   out_count_r;
    logic            out_valid_r;
    logic            flush_pending_s;
    logic            out_free_s;
    logic            load_out_s;
    logic            pop_s;

    // Handshake decode: when the output register can take the accumulator and when to pop.
    always_comb begin
        flush_pending_s = (state_r == FLUSH);
        out_free_s      = ~out_valid_r | bus.out_ready;
        load_out_s      = out_free_s & ((acc_count_r == full_count) |
                                        (flush_pending_s & (acc_count_r != zero_count)));
        // A pop is allowed into a free lane, or into lane 0 while the full
        // accumulator moves out in the same cycle. Reset gates it off so the
        // FIFO is never drained while the packer is held in reset.
        pop_s           = ~rst & ~bus.fifo_empty & ~flush_pending_s &
                          ((acc_count_r < full_count) | load_out_s);
    end

    // Flush state machine next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ACCUM: begin
                if (bus.flush) begin
                    state_nxt_s = FLUSH;
                end else begin
                    state_nxt_s = ACCUM;
                end
            end
            FLUSH: begin
                // Leave once the partial word is loaded, or at once if there was nothing to flush.
                if (load_out_s | (acc_count_r == zero_count)) begin
                    state_nxt_s = ACCUM;
                end else begin
                    state_nxt_s = FLUSH;
                end
            end
            default: begin
                state_nxt_s = ACCUM;
            end
        endcase
    end

    // Accumulator next-value logic; lanes are zeroed on unload so a partial word carries zeros.
    always_comb begin
        acc_data_nxt_s  = acc_data_r;
        acc_count_nxt_s = acc_count_r;
        if (load_out_s) begin
            acc_data_nxt_s = {dw{1'b0}};
            if (pop_s) begin
                acc_data_nxt_s[width-1:0] = bus.fifo_read_data;
                acc_count_nxt_s           = one_count;
            end else begin
                acc_count_nxt_s           = zero_count;
            end
        end else if (pop_s) begin
            for (int i = 0; i < ratio; i++) begin
                if (acc_count_r == cw'(i)) begin
                    acc_data_nxt_s[i*width +: width] = bus.fifo_read_data;
                end else begin
                    acc_data_nxt_s[i*width +: width] = acc_data_r[i*width +: width];
                end
            end
            acc_count_nxt_s = acc_count_r + one_count;
        end else begin
            acc_data_nxt_s  = acc_data_r;
            acc_count_nxt_s = acc_count_r;
        end
    end

    // State, accumulator and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ACCUM;
            acc_data_r  <= {dw{1'b0}};
            acc_count_r <= zero_count;
            out_data_r  <= {dw{1'b0}};
            out_count_r <= zero_count;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            acc_data_r  <= acc_data_nxt_s;
            acc_count_r <= acc_count_nxt_s;
            if (load_out_s) begin
                out_data_r  <= acc_data_r;
                out_count_r <= acc_count_r;
                out_valid_r <= 1'b1;
            end else if (out_valid_r & bus.out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign bus.fifo_pop  = pop_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_count = out_count_r;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Purpose: self-checking bench for fifo_word_packer (width=8, ratio=4).
//          A queue stands in for the show-ahead FIFO; packed words expected
//          from each pushed word sequence go to a scoreboard and are compared
//          when the packer hands a word downstream.
`timescale 1ns/1ps
module tb_fifo_word_packer;
    localparam int width = 8;
    localparam int ratio = 4;
    localparam int cw    = $clog2(ratio + 1);
    localparam int dw    = width * ratio;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fifo_word_packer_if #(.width(width), .ratio(ratio)) bus ();

    fifo_word_packer #(.width(width), .ratio(ratio)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [width-1:0] src[$];
    logic [dw-1:0]    sb_data[$];
    int               sb_count[$];
    int               xfer_cyc[$];

    logic [dw-1:0]    model_acc = '0;
    int               model_n = 0;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   xfers = 0;
    logic s_pop;
    logic s_valid;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Add a word to the FIFO and to the packing model; a full model word goes to the scoreboard.
    task automatic push_word(input logic [width-1:0] w);
        src.push_back(w);
        model_acc[model_n*width +: width] = w;
        model_n++;
        if (model_n == ratio) begin
            sb_data.push_back(model_acc);
            sb_count.push_back(model_n);
            model_acc = '0;
            model_n = 0;
        end
    endtask

    task automatic commit_partial();
        if (model_n > 0) begin
            sb_data.push_back(model_acc);
            sb_count.push_back(model_n);
        end
        model_acc = '0;
        model_n = 0;
    endtask

    // One clock cycle: drive at negedge, sample 1 ns before posedge, consume FIFO after posedge.
    task automatic tick();
        logic [dw-1:0] exp_d;
        int            exp_c;
        bus.fifo_empty     = (src.size() == 0);
        bus.fifo_read_data = (src.size() == 0) ? '0 : src[0];
        #4;
        s_pop   = bus.fifo_pop;
        s_valid = bus.out_valid;
        if (s_pop) begin
            checks++;
            assert (!bus.fifo_empty) else begin
                errors++;
                $error("FAIL pop_when_empty: observed pop=1 expected pop=0");
            end
        end
        if (s_valid && bus.out_ready) begin
            xfers++;
            xfer_cyc.push_back(cyc);
            checks++;
            assert (sb_data.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_word: observed 0x%0h expected none", bus.out_data);
            end
            if (sb_data.size() != 0) begin
                exp_d = sb_data.pop_front();
                exp_c = sb_count.pop_front();
                check("out_data", 64'(bus.out_data), 64'(exp_d));
                check("out_count", 64'(bus.out_count), 64'(exp_c));
            end
        end
        @(posedge clk);
        if (s_pop && src.size() > 0) begin
            void'(src.pop_front());
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((sb_data.size() > 0 || src.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_drained"}, 64'(sb_data.size() + src.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_pop;
        int t_pop;
        int t_valid;
        int v_cycles;
        int base;
        logic [dw-1:0] held;

        rst = 1'b1;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        bus.fifo_empty = 1'b0;
        bus.fifo_read_data = 8'h5A;
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_out_count", 64'(bus.out_count), 64'd0);
        check("rst_fifo_pop", 64'(bus.fifo_pop), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic packet: latency from 4th pop to out_valid, single-cycle valid.
        bus.out_ready = 1'b1;
        push_word(8'h11); push_word(8'h22); push_word(8'h33); push_word(8'h44);
        n_pop = 0; t_pop = -100; t_valid = -1; v_cycles = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (s_pop) begin
                n_pop++;
                if (n_pop == 4) t_pop = cyc - 1;
            end
            if (s_valid) begin
                v_cycles++;
                if (t_valid < 0) t_valid = cyc - 1;
            end
        end
        check("t1_latency", 64'(t_valid - t_pop), 64'd2);
        check("t1_valid_cycles", 64'(v_cycles), 64'd1);
        check("t1_sb_empty", 64'(sb_data.size()), 64'd0);

        // Backpressure: first word held, accumulator fills, pops stop.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 12; i++) push_word(8'(8'h20 + i));
        for (int i = 0; i < 12; i++) tick();
        check("t2_no_pop", 64'(s_pop), 64'd0);
        check("t2_remaining", 64'(src.size()), 64'd4);
        check("t2_valid", 64'(s_valid), 64'd1);
        check("t2_head_data", 64'(bus.out_data), 64'(sb_data[0]));
        held = bus.out_data;
        for (int i = 0; i < 3; i++) tick();
        check("t2_held_data", 64'(bus.out_data), 64'(held));
        check("t2_held_count", 64'(bus.out_count), 64'(sb_count[0]));
        base = xfers;
        bus.out_ready = 1'b1;
        drain("t2", 60);
        check("t2_xfers", 64'(xfers - base), 64'd3);

        // Flush of a partial word; no pop while the flush is pending.
        base = xfers;
        push_word(8'hAA); push_word(8'hBB);
        tick(); tick();
        commit_partial();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        for (int i = 0; i < 4; i++) push_word(8'(8'h01 + i));
        tick();
        check("t3_no_pop_in_flush", 64'(s_pop), 64'd0);
        drain("t3", 60);
        check("t3_xfers", 64'(xfers - base), 64'd2);

        // Flush with an empty accumulator: no output, one cycle in FLUSH.
        base = xfers;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("t4_no_valid_a", 64'(s_valid), 64'd0);
        for (int i = 0; i < 4; i++) push_word(8'(8'h51 + i));
        tick();
        check("t4_pop_blocked", 64'(s_pop), 64'd0);
        check("t4_no_valid_b", 64'(s_valid), 64'd0);
        tick();
        check("t4_pop_resumed", 64'(s_pop), 64'd1);
        drain("t4", 60);
        check("t4_xfers", 64'(xfers - base), 64'd1);

        // Sustained stream: a pop every cycle, packed words every 4 cycles.
        xfer_cyc.delete();
        for (int i = 0; i < 16; i++) push_word(8'(8'h80 + i));
        n_pop = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (s_pop) n_pop++;
        end
        check("t5_pops", 64'(n_pop), 64'd16);
        drain("t5", 60);
        check("t5_xfers", 64'(xfer_cyc.size()), 64'd4);
        for (int i = 1; i < 4; i++) begin
            if (i < xfer_cyc.size()) begin
                check("t5_cadence", 64'(xfer_cyc[i] - xfer_cyc[i-1]), 64'd4);
            end
        end

        // Reset mid-packet discards the partial accumulator.
        base = xfers;
        for (int i = 0; i < 3; i++) push_word(8'(8'h61 + i));
        tick(); tick(); tick();
        model_acc = '0;
        model_n = 0;
        for (int i = 0; i < 4; i++) push_word(8'(8'h71 + i));
        bus.fifo_empty = 1'b0;
        bus.fifo_read_data = src[0];
        rst = 1'b1;
        #1;
        check("t6_rst_valid", 64'(bus.out_valid), 64'd0);
        check("t6_rst_data", 64'(bus.out_data), 64'd0);
        check("t6_rst_count", 64'(bus.out_count), 64'd0);
        check("t6_rst_pop", 64'(bus.fifo_pop), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drain("t6", 60);
        check("t6_xfers", 64'(xfers - base), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_word_packer.md
FIFO_WORD_PACKER -- requirements
Module: fifo_word_packer

Interface
REQ-001 SHALL have parameter width, default 8, bits per FIFO word.
REQ-002 SHALL have parameter ratio, default 4, FIFO words per packed output word; legal range ratio >= 2.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port fifo_empty  input  1  upstream FIFO empty flag.
REQ-006 SHALL have port fifo_read_data  input  width  upstream FIFO head word; show-ahead, valid whenever fifo_empty=0.
REQ-007 SHALL have port fifo_pop  output  1  pop strobe to upstream FIFO; combinational.
REQ-008 SHALL have port flush  input  1  single-cycle request to emit a partially filled word.
REQ-009 SHALL have port out_valid  output  1  packed word available; registered.
REQ-010 SHALL have port out_ready  input  1  downstream accepts; transfer when out_valid & out_ready.
REQ-011 SHALL have port out_data  output  width*ratio  packed word; registered.
REQ-012 SHALL have port out_count  output  $clog2(ratio+1)  number of valid lanes in out_data (1..ratio); registered.

Function
REQ-013 SHALL hold an accumulator of ratio lanes plus acc_count (0..ratio), and a separate output register (out_data, out_count, out_valid).
REQ-014 SHALL place the k-th accepted word of a packet in lane k, bits [k*width +: width]; lane 0 = first word.
REQ-015 SHALL drive lanes not filled in a partial word to zero in out_data.
REQ-016 SHALL define out_free = ~out_valid | out_ready.
REQ-017 SHALL define load_out = out_free & ((acc_count == ratio) | (flush_pending & acc_count != 0)).
REQ-018 SHALL assert fifo_pop = ~fifo_empty & ~flush_pending & ((acc_count < ratio) | load_out); fifo_pop never asserts while fifo_empty=1.
REQ-019 SHALL, on fifo_pop, write fifo_read_data into lane acc_count (or lane 0 if load_out in the same cycle) at the next edge.
REQ-020 SHALL, on load_out, copy accumulator lanes and acc_count to out_data/out_count, set out_valid=1, and set acc_count to 1 if fifo_pop in the same cycle, else 0.
REQ-021 SHALL clear out_valid after a transfer (out_valid & out_ready) when load_out is not asserted in the same cycle.
REQ-022 SHALL hold out_data and out_count stable while out_valid=1 and out_ready=0.
REQ-023 SHALL have two states: ACCUM (flush_pending=0) and FLUSH (flush_pending=1).
REQ-024 SHALL transition ACCUM->FLUSH when flush=1 is sampled; a pop in that same cycle is still performed and included in the flushed word.
REQ-025 SHALL transition FLUSH->ACCUM on the edge where load_out=1, or on the first edge in FLUSH with acc_count=0 (no output produced).
REQ-026 SHALL ignore flush while in FLUSH.
REQ-027 SHALL give latency: a word popped in cycle T completing the accumulator yields out_valid=1 in cycle T+2 when out_free.
REQ-028 SHALL sustain one pop per cycle with out_ready held 1 (no bubbles at packet boundaries).

Reset
REQ-029 SHALL, while rst=1, force out_valid=0, out_data=0, out_count=0, acc_count=0, lanes=0, state ACCUM, and fifo_pop=0.
REQ-030 SHALL discard accumulator contents and any pending output on reset asserted mid-packet.

Verification (width=8, ratio=4)
REQ-031 SHALL cover: FIFO supplies 0x11,0x22,0x33,0x44, out_ready=1 -> out_valid one cycle, out_data=0x44332211, out_count=4, two cycles after the 4th pop.
REQ-032 SHALL cover: 12 words, out_ready=0 -> first word held stable, accumulator fills, fifo_pop=0 with fifo_empty=0; out_ready=1 -> all three words 0x..., in order, none lost.
REQ-033 SHALL cover: words 0xAA,0xBB then flush -> out_data=0x0000BBAA, out_count=2; no pop while in FLUSH.
REQ-034 SHALL cover: flush with acc_count=0 -> no out_valid, state returns to ACCUM after one cycle.
REQ-035 SHALL cover: 16-word stream, out_ready=1, fifo_empty=0 throughout -> fifo_pop=1 every cycle, 4 packed words on consecutive-packet cadence.
REQ-036 SHALL cover: rst pulse after 3 words -> all outputs 0; next 4 words produce exactly one word holding only those 4.
